// File: rtl/plab4_net_ring_out_sched_if.sv
// Bundle between one ring output port scheduler and its three requesters plus
// the downstream credit channel. Debug taps expose the arbitration state.
interface plab4_net_ring_out_sched_if #(
    parameter int cred_nbits = 2,
    parameter int wait_nbits = 4
);
    // Handshake: grant[k] is combinational from req_val and registered state; a
    // requester seeing grant[k]=1 must hold its message valid in that same cycle,
    // and the downstream enqueue (xfer) happens on that clock edge. credit_ret is a
    // one-cycle pulse per freed downstream entry.
    logic [2:0]                 req_val;
    logic [2:0]                 grant;
    logic                       xfer;
    logic                       credit_ret;
    logic [cred_nbits-1:0]      credits;
    logic                       cr_err;
    logic [1:0]                 dbg_last_grant;
    logic [2:0][wait_nbits-1:0] dbg_wait;

    modport master (
        output req_val, credit_ret,
        input  grant, xfer, credits, cr_err, dbg_last_grant, dbg_wait
    );

    modport slave (
        input  req_val, credit_ret,
        output grant, xfer, credits, cr_err, dbg_last_grant, dbg_wait
    );
endinterface

// File: rtl/plab4_net_ring_out_sched.sv
// Credit-tracking, bubble-aware round-robin scheduler for one ring output port,
// with a starvation override that forces a long-waiting requester through.
module plab4_net_ring_out_sched #(
    parameter int p_num_credits  = 2,
    parameter int p_bubble       = 1,
    parameter int p_starve_limit = 15,
    parameter int p_wait_nbits   = 4,
    localparam int c_cred_nbits  = $clog2(p_num_credits + 1)
) (
    input logic clk,
    input logic reset,
    plab4_net_ring_out_sched_if.slave bus
);
    // Injection keeps one slot free so ring traffic can always drain.
    localparam int c_inj_min = (p_bubble != 0) ? 2 : 1;

    logic [c_cred_nbits-1:0] credits_q;
    logic [1:0]              last_grant_q;
    logic [p_wait_nbits-1:0] wait_q [3];
    logic                    cr_err_q;

    logic [2:0] elig;
    logic [2:0] starve;
    logic [2:0] grant_c;
    logic [2:0] grant;
    logic [1:0] grant_idx;
    logic       xfer;
    logic       credits_full;

    always_comb begin
        elig[0] = bus.req_val[0] & (credits_q != '0);
        elig[1] = bus.req_val[1] & (credits_q >= c_cred_nbits'(c_inj_min));
        elig[2] = bus.req_val[2] & (credits_q != '0);
        for (int k = 0; k < 3; k++) begin
            starve[k] = elig[k] & (wait_q[k] == p_wait_nbits'(p_starve_limit));
        end
    end

    always_comb begin
        grant_c = 3'b000;
        if (starve[0])      grant_c = 3'b001;
        else if (starve[1]) grant_c = 3'b010;
        else if (starve[2]) grant_c = 3'b100;
        else begin
            // Scan starts just after the last winner, which goes last.
            case (last_grant_q)
                2'd0: begin
                    if (elig[1])      grant_c = 3'b010;
                    else if (elig[2]) grant_c = 3'b100;
                    else if (elig[0]) grant_c = 3'b001;
                end
                2'd1: begin
                    if (elig[2])      grant_c = 3'b100;
                    else if (elig[0]) grant_c = 3'b001;
                    else if (elig[1]) grant_c = 3'b010;
                end
                default: begin
                    if (elig[0])      grant_c = 3'b001;
                    else if (elig[1]) grant_c = 3'b010;
                    else if (elig[2]) grant_c = 3'b100;
                end
            endcase
        end
    end

    always_comb begin
        grant     = reset ? grant_c : 3'b000;
        xfer      = |grant;
        grant_idx = 2'd0;
        if (grant[1]) grant_idx = 2'd1;
        if (grant[2]) grant_idx = 2'd2;
        credits_full = (credits_q == c_cred_nbits'(p_num_credits));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            credits_q    <= c_cred_nbits'(p_num_credits);
            last_grant_q <= 2'd2;
            cr_err_q     <= 1'b0;
            for (int k = 0; k < 3; k++) wait_q[k] <= '0;
        end else begin
            if (xfer) last_grant_q <= grant_idx;
            for (int k = 0; k < 3; k++) begin
                if (grant[k] || !bus.req_val[k])
                    wait_q[k] <= '0;
                else if (wait_q[k] != p_wait_nbits'(p_starve_limit))
                    wait_q[k] <= wait_q[k] + 1'b1;
            end
            cr_err_q <= 1'b0;
            case ({xfer, bus.credit_ret})
                2'b10: credits_q <= credits_q - 1'b1;
                2'b01: begin
                    if (credits_full) cr_err_q <= 1'b1;
                    else              credits_q <= credits_q + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.grant          = grant;
        bus.xfer           = xfer;
        bus.credits        = credits_q;
        bus.cr_err         = cr_err_q;
        bus.dbg_last_grant = last_grant_q;
        for (int k = 0; k < 3; k++) bus.dbg_wait[k] = wait_q[k];
    end
endmodule

// File: tb/tb_plab4_net_ring_out_sched.sv
// Directed bench for the ring output scheduler: grants go through an expected
// queue, registered credit state is checked after each edge.
module tb_plab4_net_ring_out_sched;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;
    logic [3:0] exp_q[$];

    plab4_net_ring_out_sched_if #(.cred_nbits(2), .wait_nbits(4)) bus ();

    plab4_net_ring_out_sched #(
        .p_num_credits(2), .p_bubble(1), .p_starve_limit(15), .p_wait_nbits(4)
    ) dut (
        .clk(clk),
        .reset(rst_n),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle from posedge+1; grant is checked mid-cycle, then advance.
    task automatic step(input logic [2:0] req, input logic cret, input logic [2:0] exp_g);
        logic [3:0] e;
        bus.req_val    = req;
        bus.credit_ret = cret;
        exp_q.push_back({|exp_g, exp_g});
        #2;
        e = exp_q.pop_front();
        chk("xfer_grant", {28'd0, bus.xfer, bus.grant}, {28'd0, e});
        @(posedge clk);
        #1;
    endtask

    task automatic regs(input string tag, input logic [1:0] cred, input logic err);
        chk({tag, "_credits"}, {30'd0, bus.credits}, {30'd0, cred});
        chk({tag, "_cr_err"}, {31'd0, bus.cr_err}, {31'd0, err});
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        bus.req_val    = 3'b000;
        bus.credit_ret = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [2:0] rr_exp [6];
        int idle;
        errors = 0;
        checks = 0;
        rr_exp[0] = 3'b001; rr_exp[1] = 3'b010; rr_exp[2] = 3'b100;
        rr_exp[3] = 3'b001; rr_exp[4] = 3'b010; rr_exp[5] = 3'b100;

        do_reset();
        regs("reset", 2'd2, 1'b0);
        chk("reset_last", {30'd0, bus.dbg_last_grant}, 32'd2);

        // Full load with credits returned every cycle: strict rotation.
        for (int i = 0; i < 6; i++) begin
            step(3'b111, 1'b1, rr_exp[i]);
            regs("rr", 2'd2, 1'b0);
        end

        // Credit return into a full counter is dropped and flagged.
        step(3'b000, 1'b1, 3'b000);
        regs("overflow", 2'd2, 1'b1);
        step(3'b001, 1'b1, 3'b001);
        regs("ret_with_xfer", 2'd2, 1'b0);

        // Drain credits with in0 only.
        do_reset();
        idle = $urandom_range(1, 4);
        for (int i = 0; i < idle; i++) step(3'b000, 1'b0, 3'b000);
        step(3'b001, 1'b0, 3'b001);
        regs("drain1", 2'd1, 1'b0);
        step(3'b001, 1'b0, 3'b001);
        regs("drain2", 2'd0, 1'b0);
        step(3'b001, 1'b0, 3'b000);
        regs("drain3", 2'd0, 1'b0);

        // Bubble rule: injection waits until two credits are free.
        step(3'b010, 1'b1, 3'b000);
        regs("bubble0", 2'd1, 1'b0);
        step(3'b010, 1'b0, 3'b000);
        regs("bubble1", 2'd1, 1'b0);
        step(3'b010, 1'b1, 3'b000);
        regs("bubble2", 2'd2, 1'b0);
        step(3'b010, 1'b0, 3'b010);
        regs("bubble3", 2'd1, 1'b0);
        chk("bubble_last", {30'd0, bus.dbg_last_grant}, 32'd1);

        // Use the last credit on in2 so round-robin next favours in0.
        step(3'b100, 1'b0, 3'b100);
        regs("pre_starve", 2'd0, 1'b0);
        for (int i = 0; i < 15; i++) step(3'b100, 1'b0, 3'b000);
        chk("wait2_sat", {28'd0, bus.dbg_wait[2]}, 32'd15);
        step(3'b111, 1'b1, 3'b000);
        regs("starve_ret", 2'd1, 1'b0);
        chk("wait2_hold", {28'd0, bus.dbg_wait[2]}, 32'd15);
        step(3'b111, 1'b0, 3'b100);
        regs("starve_win", 2'd0, 1'b0);
        chk("wait0_after", {28'd0, bus.dbg_wait[0]}, 32'd2);

        // Reset in the middle of traffic.
        rst_n          = 1'b0;
        bus.req_val    = 3'b111;
        bus.credit_ret = 1'b1;
        exp_q.push_back(4'b0000);
        #2;
        chk("grant_in_reset", {28'd0, bus.xfer, bus.grant}, {28'd0, exp_q.pop_front()});
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        regs("mid_reset", 2'd2, 1'b0);
        chk("mid_reset_wait", {20'd0, bus.dbg_wait[2], bus.dbg_wait[1], bus.dbg_wait[0]}, 32'd0);
        step(3'b111, 1'b0, 3'b001);
        regs("post_reset", 2'd1, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
